// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle load/store unit between the core datapath and a
// req/ack word-addressed data bus. Stalls the core while an access is in
// flight, returns aligned and extended load data, and flags misaligned
// accesses and bus timeouts.
module load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Load,
    input  logic        MemWrite,
    input  logic [1:0]  AccessMode,
    input  logic        LoadUnsigned,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        MisalignedFault,
    output logic        BusError,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    // The counter only has to reach TIMEOUT-1, so log2(TIMEOUT) bits suffice.
    localparam int              CNT_W      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);
    localparam bit              TIMEOUT_EN = (TIMEOUT != 0);

    state_t             state;
    state_t             state_next;
    logic               is_access;
    logic               misaligned;
    logic               acc;
    logic               timeout_hit;
    logic [CNT_W-1:0]   req_count;
    logic [1:0]         lane;
    logic [1:0]         mode_q;
    logic               unsigned_q;
    logic [3:0]         be_next;
    logic [31:0]        wdata_next;
    logic [7:0]         byte_sel;
    logic [15:0]        half_sel;
    logic [31:0]        load_value;

    assign is_access       = Load | MemWrite;
    assign MisalignedFault = misaligned;
    assign acc             = is_access & ~misaligned;
    assign Stall           = acc & (state != DONE);
    assign bus_req         = (state == REQ);
    assign timeout_hit     = TIMEOUT_EN && (req_count == CNT_LAST);

    // Alignment check; the reserved access mode faults whenever it is used.
    always_comb begin
        misaligned = 1'b0;
        case (AccessMode)
            2'b01:   misaligned = Addr[0];
            2'b10:   misaligned = (Addr[1:0] != 2'b00);
            2'b11:   misaligned = is_access;
            default: misaligned = 1'b0;
        endcase
    end

    // Byte enables and lane-replicated store data for the access being issued.
    always_comb begin
        be_next    = 4'b1111;
        wdata_next = WriteData;
        case (AccessMode)
            2'b00: begin
                be_next    = 4'b0001 << Addr[1:0];
                wdata_next = {4{WriteData[7:0]}};
            end
            2'b01: begin
                be_next    = 4'b0011 << {Addr[1], 1'b0};
                wdata_next = {2{WriteData[15:0]}};
            end
            default: begin
                be_next    = 4'b1111;
                wdata_next = WriteData;
            end
        endcase
    end

    // Pick the addressed lane out of the read word and sign/zero extend it.
    always_comb begin
        byte_sel   = bus_rdata[7:0];
        half_sel   = lane[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        load_value = bus_rdata;
        case (lane)
            2'd0:    byte_sel = bus_rdata[7:0];
            2'd1:    byte_sel = bus_rdata[15:8];
            2'd2:    byte_sel = bus_rdata[23:16];
            default: byte_sel = bus_rdata[31:24];
        endcase
        case (mode_q)
            2'b00:   load_value = {{24{~unsigned_q & byte_sel[7]}}, byte_sel};
            2'b01:   load_value = {{16{~unsigned_q & half_sel[15]}}, half_sel};
            default: load_value = bus_rdata;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: an ack in the last allowed REQ cycle beats the timeout.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (acc) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (bus_ack || timeout_hit) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bus request registers, timeout counter and the DONE-cycle results.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus_we     <= 1'b0;
            bus_addr   <= 32'd0;
            bus_be     <= 4'd0;
            bus_wdata  <= 32'd0;
            lane       <= 2'd0;
            mode_q     <= 2'd0;
            unsigned_q <= 1'b0;
            ReadData   <= 32'd0;
            BusError   <= 1'b0;
            req_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    BusError  <= 1'b0;
                    req_count <= '0;
                    if (acc) begin
                        bus_we     <= MemWrite;
                        bus_addr   <= {Addr[31:2], 2'b00};
                        bus_be     <= be_next;
                        bus_wdata  <= wdata_next;
                        lane       <= Addr[1:0];
                        mode_q     <= AccessMode;
                        unsigned_q <= LoadUnsigned;
                    end
                end
                REQ: begin
                    if (bus_ack) begin
                        ReadData  <= bus_we ? 32'd0 : load_value;
                        req_count <= '0;
                    end else if (timeout_hit) begin
                        ReadData  <= 32'd0;
                        BusError  <= 1'b1;
                        req_count <= '0;
                    end else begin
                        req_count <= req_count + 1'b1;
                    end
                end
                DONE: begin
                    BusError  <= 1'b0;
                    req_count <= '0;
                end
                default: begin
                    BusError  <= 1'b0;
                    req_count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized accesses against a byte-level
// reference model of the load/store unit, with a short timeout.
module tb_load_store_unit;

    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        Load;
    logic        MemWrite;
    logic [1:0]  AccessMode;
    logic        LoadUnsigned;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Stall;
    logic        MisalignedFault;
    logic        BusError;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int          total = 0;
    int          bad = 0;
    logic [31:0] expReadData = 32'd0;

    load_store_unit #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk),
        .reset(reset),
        .Load(Load),
        .MemWrite(MemWrite),
        .AccessMode(AccessMode),
        .LoadUnsigned(LoadUnsigned),
        .Addr(Addr),
        .WriteData(WriteData),
        .ReadData(ReadData),
        .Stall(Stall),
        .MisalignedFault(MisalignedFault),
        .BusError(BusError),
        .bus_req(bus_req),
        .bus_we(bus_we),
        .bus_addr(bus_addr),
        .bus_be(bus_be),
        .bus_wdata(bus_wdata),
        .bus_ack(bus_ack),
        .bus_rdata(bus_rdata)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic l, input logic mw, input logic [1:0] mode,
                                 input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
        Load         = l;
        MemWrite     = mw;
        AccessMode   = mode;
        LoadUnsigned = uns;
        Addr         = addr;
        WriteData    = wdata;
    endtask

    function automatic int accessSize(input logic [1:0] mode);
        if (mode == 2'b00) return 1;
        if (mode == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic modelMisaligned(input logic l, input logic mw, input logic [1:0] mode,
                                             input logic [31:0] addr);
        if (mode == 2'b11) return l | mw;
        return (addr % accessSize(mode)) != 0;
    endfunction

    function automatic logic [3:0] modelBe(input logic [1:0] mode, input logic [31:0] addr);
        int off = int'(addr % 4);
        int size = accessSize(mode);
        logic [3:0] be = 4'd0;
        for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + size);
        return be;
    endfunction

    function automatic logic [31:0] modelWdata(input logic [1:0] mode, input logic [31:0] wd);
        int size = accessSize(mode);
        logic [31:0] w = 32'd0;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = wd[8*(i % size) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] modelLoad(input logic [1:0] mode, input logic uns,
                                              input logic [31:0] addr, input logic [31:0] rdata);
        int     bits = 8 * accessSize(mode);
        int     off = int'(addr % 4);
        longint v = longint'(rdata);
        v = (v >> (8 * off)) & ((64'sd1 <<< bits) - 1);
        if (!uns && bits < 32 && v >= (64'sd1 <<< (bits - 1))) v = v - (64'sd1 <<< bits);
        return 32'(v);
    endfunction

    // One complete memory instruction; ackAt is the REQ cycle that sees bus_ack (0 = never).
    task automatic doAccess(input string name, input logic l, input logic mw, input logic [1:0] mode,
                            input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rdata, input int ackAt);
        logic mis;
        bit   acked;
        bit   timedOut;
        int   k;
        applyStimulus(l, mw, mode, uns, addr, wdata);
        bus_ack   = 1'b0;
        bus_rdata = rdata;
        #1;
        mis = modelMisaligned(l, mw, mode, addr);
        checkOutput({name, " fault"}, MisalignedFault, mis);
        checkOutput({name, " stall idle"}, Stall, (l | mw) & ~mis);
        if (mis || !(l | mw)) begin
            for (int c = 0; c < 2; c++) begin
                step();
                checkOutput({name, " no req"}, bus_req, 1'b0);
                checkOutput({name, " no stall"}, Stall, 1'b0);
            end
            checkOutput({name, " rdata kept"}, ReadData, expReadData);
            applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
            return;
        end
        k = 0;
        acked = 0;
        timedOut = 0;
        while (!acked && !timedOut) begin
            step();
            k++;
            checkOutput({name, " req"}, bus_req, 1'b1);
            checkOutput({name, " we"}, bus_we, mw);
            checkOutput({name, " addr"}, bus_addr, {addr[31:2], 2'b00});
            checkOutput({name, " be"}, bus_be, modelBe(mode, addr));
            checkOutput({name, " wdata"}, bus_wdata, modelWdata(mode, wdata));
            checkOutput({name, " stall req"}, Stall, 1'b1);
            if (k == ackAt) begin
                bus_ack = 1'b1;
                acked = 1;
            end else if (k == TIMEOUT) begin
                timedOut = 1;
            end
        end
        step();
        bus_ack = 1'b0;
        if (acked && !mw) expReadData = modelLoad(mode, uns, addr, rdata);
        else expReadData = 32'd0;
        checkOutput({name, " done req"}, bus_req, 1'b0);
        checkOutput({name, " done stall"}, Stall, 1'b0);
        checkOutput({name, " rdata"}, ReadData, expReadData);
        checkOutput({name, " buserr"}, BusError, timedOut);
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
        step();
        checkOutput({name, " after req"}, bus_req, 1'b0);
        checkOutput({name, " after buserr"}, BusError, 1'b0);
        checkOutput({name, " after rdata"}, ReadData, expReadData);
    endtask

    // Directed test-plan cases, a mid-access reset, then random accesses.
    initial begin
        int mode;
        int sel;
        logic [31:0] a;
        reset     = 1'b1;
        bus_ack   = 1'b0;
        bus_rdata = 32'd0;
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
        step();
        step();
        reset = 1'b0;
        #1;
        checkOutput("reset req", bus_req, 1'b0);
        checkOutput("reset we", bus_we, 1'b0);
        checkOutput("reset addr", bus_addr, 32'd0);
        checkOutput("reset be", bus_be, 4'd0);
        checkOutput("reset wdata", bus_wdata, 32'd0);
        checkOutput("reset rdata", ReadData, 32'd0);
        checkOutput("reset buserr", BusError, 1'b0);
        checkOutput("reset stall", Stall, 1'b0);

        doAccess("lb", 1, 0, 2'b00, 0, 32'h0000_1003, 32'd0, 32'h80FF_FF12, 1);
        doAccess("lbu", 1, 0, 2'b00, 1, 32'h0000_1003, 32'd0, 32'h80FF_FF12, 1);
        doAccess("sh", 0, 1, 2'b01, 0, 32'h0000_2002, 32'h1234_ABCD, 32'd0, 4);
        doAccess("lw mis", 1, 0, 2'b10, 0, 32'h0000_3001, 32'd0, 32'd0, 1);
        doAccess("mode11", 1, 0, 2'b11, 0, 32'h0000_3001, 32'd0, 32'd0, 1);
        doAccess("lw timeout", 1, 0, 2'b10, 0, 32'h0000_3000, 32'd0, 32'hCAFE_F00D, 0);
        doAccess("lw late ack", 1, 0, 2'b10, 0, 32'h0000_3000, 32'd0, 32'hCAFE_F00D, TIMEOUT);
        doAccess("lh", 1, 0, 2'b01, 0, 32'h0000_0502, 32'd0, 32'h9876_1234, 2);
        doAccess("ld+st", 1, 1, 2'b00, 0, 32'h0000_0000, 32'h0000_0055, 32'hFFFF_FFFF, 1);

        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_4000, 32'd0);
        bus_ack = 1'b0;
        step();
        checkOutput("rst req1", bus_req, 1'b1);
        step();
        checkOutput("rst req2", bus_req, 1'b1);
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
        step();
        reset     = 1'b0;
        bus_ack   = 1'b1;
        bus_rdata = 32'hDEAD_BEEF;
        #1;
        checkOutput("rst req", bus_req, 1'b0);
        checkOutput("rst we", bus_we, 1'b0);
        checkOutput("rst addr", bus_addr, 32'd0);
        checkOutput("rst be", bus_be, 4'd0);
        checkOutput("rst wdata", bus_wdata, 32'd0);
        checkOutput("rst rdata", ReadData, 32'd0);
        checkOutput("rst buserr", BusError, 1'b0);
        checkOutput("rst stall", Stall, 1'b0);
        step();
        checkOutput("rst ack ignored req", bus_req, 1'b0);
        checkOutput("rst ack ignored rdata", ReadData, 32'd0);
        bus_ack = 1'b0;
        expReadData = 32'd0;
        step();
        checkOutput("rst idle req", bus_req, 1'b0);

        for (int n = 0; n < 40; n++) begin
            mode = $urandom_range(0, 3);
            sel  = $urandom_range(0, 3);
            a    = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~(32'(accessSize(2'(mode))) - 32'd1);
            doAccess("rand", (sel != 1), (sel == 1 || sel == 2), 2'(mode), 1'($urandom_range(0, 1)),
                     a, $urandom, $urandom, $urandom_range(0, TIMEOUT));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
